regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Arbitrates the register file's single write port among NREQ writeback sources (ALU, FPU, load unit).
- Keeps a pending-write scoreboard for both the integer bank (x) and the float bank (f).
- Produces the decode-stage stall for RAW and WAW hazards.
- Sits between the execution units and the register file; drives its RegWrite, WriteReg, WriteData and writef inputs.

Parameters:
- NREQ, 3, number of writeback requesters; index 0 is lowest in the initial round-robin order.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  requester i has a result
- req_ready  out  NREQ  grant; the transfer happens when valid&ready
- req_rd  in  5*NREQ  destination of requester i, slice [5i+4:5i]
- req_f  in  NREQ  destination is in the float bank
- req_data  in  XLEN*NREQ  result of requester i
- wb_we  out  1  register-file write enable (RegWrite)
- wb_rd  out  5  register-file WriteReg
- wb_f  out  1  register-file writef
- wb_data  out  XLEN  register-file WriteData
- iss_valid  in  1  decode wants to issue an instruction this cycle
- iss_has_rd  in  1  the instruction writes a destination
- iss_rd  in  5  destination index
- iss_rd_f  in  1  destination is in the float bank
- iss_rs1, iss_rs2  in  5 each  source indices
- iss_rs1_f, iss_rs2_f  in  1 each  source bank selects
- iss_use_rs1, iss_use_rs2  in  1 each  the source is actually read
- stall  out  1  decode must hold; the issue is not accepted
- pending_cnt  out  6  number of scoreboard bits set (debug)

Behaviour:
- Reset:
  - All scoreboard bits 0; rr pointer 0.
  - wb_we=0, wb_rd=0, wb_f=0, wb_data=0, req_ready=0, pending_cnt=0.
  - Reset mid-operation drops all in-flight grants and pending bits. No register-file write occurs in the reset cycle or the cycle after.
- Arbitration:
  - Combinational, one grant per cycle.
  - Round-robin search starts at the rr pointer. The pointer moves to winner+1 (mod NREQ) after each grant and is unchanged when nothing is granted.
  - req_ready is one-hot or zero. It may assert only when the matching req_valid is high.
  - A requester holds valid, rd, f and data stable until granted.
- Writeback latency:
  - The granted request is registered: wb_* are valid exactly 1 cycle after the grant.
  - wb_we=1 for one cycle per grant.
  - An integer-bank write to x0 still produces wb_we=1; the register file ignores it.
- Scoreboard:
  - Two 32-bit vectors, sb_x and sb_f.
  - Issue accepted (iss_valid & ~stall & iss_has_rd): set sb[iss_rd], except integer x0, which is never set.
  - Grant: clear sb[req_rd] of the granted requester in the same clock edge as wb_* is registered.
  - Set and clear of the same bit in the same cycle: set wins.
- Stall (combinational):
  - stall = iss_valid & (RAW | WAW).
  - RAW: (use_rs1 & sb[rs1]) | (use_rs2 & sb[rs2]), looked up in the selected bank.
  - WAW: iss_has_rd & sb[rd] in the selected bank.
  - Integer x0 is never busy.
  - Without the bypass feature, a bit being cleared this cycle still counts as busy.
- pending_cnt: registered popcount of sb_x|sb_f contributions. Range 0..63, since x0 is excluded.

Optional Feature:
- Macro: WB_SCOREBOARD_BYPASS_EN.
- Defined: a source or destination whose scoreboard bit is cleared by this cycle's grant is not busy. Decode may issue in the same cycle, and the consumer reads through the register file one cycle later, after wb_* has written.
- Undefined: such a register stays busy until the cycle after the clear, costing one extra stall cycle.

Test Plan:
- Reset, then idle: wb_we=0, stall=0, pending_cnt=0.
- Contention: after reset, all 3 requesters valid continuously with rd=5,6,7 -> grants in order 0,1,2,0; each wb_we pulse appears 1 cycle after its grant with the matching rd and data.
- RAW: issue rd=x8 (int); next cycle issue with rs1=x8 -> stall=1 until requester 2 writes x8.
  - Without the macro: stall drops the cycle after the grant.
  - With WB_SCOREBOARD_BYPASS_EN: stall drops in the grant cycle.
- Bank separation: pending f3 -> issue reading x3 gives stall=0; issue reading f3 gives stall=1.
- WAW and x0: issue rd=x0 -> sb unchanged, a later rs1=x0 gives no stall; issue rd=f9 twice back-to-back -> second issue stalled.
- Reset mid-operation: 2 pending bits, valid requests, rst for 1 cycle -> pending_cnt=0, no wb_we that cycle or the next, stall=0.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Bundles the writeback request bus, the register-file write port, and the
// decode issue/stall handshake of the writeback scheduler.
//
//   master : execution units + decode side (drives requests and issue info)
//   slave  : regfile_wb_scheduler (drives grants, write port, stall, debug)
//
// Request fields are packed per requester i:
//   req_rd[5i+4:5i], req_data[XLEN*i+XLEN-1:XLEN*i], req_valid[i], req_f[i]
interface regfile_wb_scheduler_if #(
   parameter int NREQ = 3,
   parameter int XLEN = 32
);
   // writeback requesters
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [5*NREQ-1:0]    req_rd;
   logic [NREQ-1:0]      req_f;
   logic [XLEN*NREQ-1:0] req_data;

   // register-file write port
   logic                 wb_we;
   logic [4:0]           wb_rd;
   logic                 wb_f;
   logic [XLEN-1:0]      wb_data;

   // decode issue / hazard interface
   logic                 iss_valid;
   logic                 iss_has_rd;
   logic [4:0]           iss_rd;
   logic                 iss_rd_f;
   logic [4:0]           iss_rs1;
   logic [4:0]           iss_rs2;
   logic                 iss_rs1_f;
   logic                 iss_rs2_f;
   logic                 iss_use_rs1;
   logic                 iss_use_rs2;
   logic                 stall;
   logic [5:0]           pending_cnt;

   modport master (
      output req_valid, req_rd, req_f, req_data,
      output iss_valid, iss_has_rd, iss_rd, iss_rd_f,
      output iss_rs1, iss_rs2, iss_rs1_f, iss_rs2_f, iss_use_rs1, iss_use_rs2,
      input  req_ready, wb_we, wb_rd, wb_f, wb_data, stall, pending_cnt
   );

   modport slave (
      input  req_valid, req_rd, req_f, req_data,
      input  iss_valid, iss_has_rd, iss_rd, iss_rd_f,
      input  iss_rs1, iss_rs2, iss_rs1_f, iss_rs2_f, iss_use_rs1, iss_use_rs2,
      output req_ready, wb_we, wb_rd, wb_f, wb_data, stall, pending_cnt
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler.
//
// Arbitrates the single register-file write port among NREQ writeback
// sources with a round-robin arbiter, registers the winner onto the write
// port (one cycle latency), and tracks outstanding destination writes for
// the integer (x) and float (f) banks to raise the decode stall on RAW/WAW
// hazards.
//
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - regfile_wb_scheduler_if.slave: req_* (requesters), wb_* (register
//          file write port), iss_* / stall (decode), pending_cnt (debug)
//
// Optional feature macro: WB_SCOREBOARD_BYPASS_EN
//   Defined   : a register whose pending bit is cleared by this cycle's grant
//               is already treated as not busy.
//   Undefined : it stays busy until the cycle after the clear.
module regfile_wb_scheduler #(
   parameter int NREQ = 3,
   parameter int XLEN = 32
) (
   input logic                   clk,
   input logic                   rst,
   regfile_wb_scheduler_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // per-requester views of the packed request bus
   logic [4:0]      rd_arr   [NREQ];
   logic [XLEN-1:0] data_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign rd_arr[gi]   = bus.req_rd[5*gi +: 5];
         assign data_arr[gi] = bus.req_data[XLEN*gi +: XLEN];
      end
   endgenerate

   // state
   logic [PW-1:0]   rr_ptr_reg;
   logic [PW-1:0]   rr_ptr_next;
   logic [31:0]     sb_x_reg;
   logic [31:0]     sb_x_next;
   logic [31:0]     sb_f_reg;
   logic [31:0]     sb_f_next;
   logic [5:0]      pending_cnt_reg;
   logic [5:0]      pending_cnt_next;
   logic            wb_we_reg;
   logic [4:0]      wb_rd_reg;
   logic            wb_f_reg;
   logic [XLEN-1:0] wb_data_reg;

   // arbitration
   logic            gnt_any;
   logic [PW-1:0]   gnt_idx;
   logic [NREQ-1:0] gnt_vec;
   logic [4:0]      win_rd;
   logic            win_f;

   // scoreboard update / hazard lookup
   logic [31:0]     clr_x;
   logic [31:0]     clr_f;
   logic [31:0]     set_x;
   logic [31:0]     set_f;
   logic [31:0]     busy_x;
   logic [31:0]     busy_f;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            rd_busy;
   logic            stall_int;
   logic            accept;

   function automatic logic [5:0] popcnt32(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

   // Round-robin search starting at rr_ptr_reg. No grants are issued while
   // reset is asserted so nothing in flight survives a reset.
   always_comb begin
      int          idx;
      logic [PW-1:0] cand;
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_vec = '0;
      idx     = 0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_reg) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         cand = PW'(idx);
         if (!gnt_any && bus.req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (rst) begin
         gnt_any = 1'b0;
      end
      if (gnt_any) begin
         gnt_vec[gnt_idx] = 1'b1;
      end
   end

   assign win_rd = rd_arr[gnt_idx];
   assign win_f  = bus.req_f[gnt_idx];

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (gnt_any) begin
         rr_ptr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Scoreboard clear from the grant, hazard lookup, and set from issue.
   always_comb begin
      clr_x = '0;
      clr_f = '0;
      if (gnt_any) begin
         if (win_f) begin
            clr_f[win_rd] = 1'b1;
         end else begin
            clr_x[win_rd] = 1'b1;
         end
      end

`ifdef WB_SCOREBOARD_BYPASS_EN
      // The grant's write lands before the consumer reads, so a bit being
      // cleared now no longer blocks issue.
      busy_x = sb_x_reg & ~clr_x;
      busy_f = sb_f_reg & ~clr_f;
`else
      busy_x = sb_x_reg;
      busy_f = sb_f_reg;
`endif
      busy_x[0] = 1'b0;   // x0 is hardwired, never a hazard

      rs1_busy  = bus.iss_rs1_f ? busy_f[bus.iss_rs1] : busy_x[bus.iss_rs1];
      rs2_busy  = bus.iss_rs2_f ? busy_f[bus.iss_rs2] : busy_x[bus.iss_rs2];
      rd_busy   = bus.iss_rd_f  ? busy_f[bus.iss_rd]  : busy_x[bus.iss_rd];

      stall_int = bus.iss_valid & ((bus.iss_use_rs1 & rs1_busy) |
                                   (bus.iss_use_rs2 & rs2_busy) |
                                   (bus.iss_has_rd  & rd_busy));
      accept    = bus.iss_valid & ~stall_int & bus.iss_has_rd & ~rst;

      set_x = '0;
      set_f = '0;
      if (accept) begin
         if (bus.iss_rd_f) begin
            set_f[bus.iss_rd] = 1'b1;
         end else if (bus.iss_rd != 5'd0) begin
            set_x[bus.iss_rd] = 1'b1;
         end
      end

      // set applied after clear so a same-cycle set wins
      sb_x_next        = (sb_x_reg & ~clr_x) | set_x;
      sb_f_next        = (sb_f_reg & ~clr_f) | set_f;
      pending_cnt_next = popcnt32(sb_x_next) + popcnt32(sb_f_next);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg      <= '0;
         sb_x_reg        <= '0;
         sb_f_reg        <= '0;
         pending_cnt_reg <= '0;
         wb_we_reg       <= 1'b0;
         wb_rd_reg       <= '0;
         wb_f_reg        <= 1'b0;
         wb_data_reg     <= '0;
      end else begin
         rr_ptr_reg      <= rr_ptr_next;
         sb_x_reg        <= sb_x_next;
         sb_f_reg        <= sb_f_next;
         pending_cnt_reg <= pending_cnt_next;
         wb_we_reg       <= gnt_any;
         if (gnt_any) begin
            wb_rd_reg   <= win_rd;
            wb_f_reg    <= win_f;
            wb_data_reg <= data_arr[gnt_idx];
         end
      end
   end

   // Write enable is masked during reset so a grant registered just before
   // reset never reaches the register file.
   assign bus.req_ready   = gnt_vec;
   assign bus.wb_we       = wb_we_reg & ~rst;
   assign bus.wb_rd       = wb_rd_reg;
   assign bus.wb_f        = wb_f_reg;
   assign bus.wb_data     = wb_data_reg;
   assign bus.stall       = stall_int;
   assign bus.pending_cnt = pending_cnt_reg;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler. Expected register-file
// writes are queued when the granting stimulus is driven and compared by a
// monitor whenever wb_we is seen; per-scenario tasks check grants, stall,
// and pending_cnt inline.
module tb_regfile_wb_scheduler;
   localparam int NREQ = 3;
   localparam int XLEN = 32;

   typedef struct packed {
      logic [4:0]  rd;
      logic        f;
      logic [31:0] data;
   } wb_exp_t;

   logic    clk;
   logic    rst;
   int      checks;
   int      errors;
   wb_exp_t exp_q [$];
   int      order [4] = '{0, 1, 2, 0};

   regfile_wb_scheduler_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

   regfile_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard monitor: every write must match the oldest expectation
   always @(negedge clk) begin
      wb_exp_t e;
      if (bus.wb_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got rd=%0d f=%0d data=%h, expected no write",
                     bus.wb_rd, bus.wb_f, bus.wb_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.wb_rd !== e.rd || bus.wb_f !== e.f || bus.wb_data !== e.data) begin
               errors++;
               $display("FAIL wb_data: got rd=%0d f=%0d data=%h, expected rd=%0d f=%0d data=%h",
                        bus.wb_rd, bus.wb_f, bus.wb_data, e.rd, e.f, e.data);
            end else begin
               $display("wb write rd=%0d f=%0d data=%h", bus.wb_rd, bus.wb_f, bus.wb_data);
            end
         end
      end
   end

   task automatic idle_inputs();
      bus.req_valid   = '0;
      bus.req_rd      = '0;
      bus.req_f       = '0;
      bus.req_data    = '0;
      bus.iss_valid   = 1'b0;
      bus.iss_has_rd  = 1'b0;
      bus.iss_rd      = '0;
      bus.iss_rd_f    = 1'b0;
      bus.iss_rs1     = '0;
      bus.iss_rs2     = '0;
      bus.iss_rs1_f   = 1'b0;
      bus.iss_rs2_f   = 1'b0;
      bus.iss_use_rs1 = 1'b0;
      bus.iss_use_rs2 = 1'b0;
   endtask

   task automatic set_req(input int i, input logic v, input logic [4:0] rd,
                          input logic f, input logic [31:0] d);
      bus.req_valid[i]          = v;
      bus.req_rd[5*i +: 5]      = rd;
      bus.req_f[i]              = f;
      bus.req_data[32*i +: 32]  = d;
   endtask

   task automatic set_iss(input logic v, input logic has_rd, input logic [4:0] rd,
                          input logic rd_f, input logic use1, input logic [4:0] rs1,
                          input logic rs1_f, input logic use2, input logic [4:0] rs2,
                          input logic rs2_f);
      bus.iss_valid   = v;
      bus.iss_has_rd  = has_rd;
      bus.iss_rd      = rd;
      bus.iss_rd_f    = rd_f;
      bus.iss_use_rs1 = use1;
      bus.iss_rs1     = rs1;
      bus.iss_rs1_f   = rs1_f;
      bus.iss_use_rs2 = use2;
      bus.iss_rs2     = rs2;
      bus.iss_rs2_f   = rs2_f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.req_valid = '1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b0 || bus.req_ready !== 3'b000) begin
         errors++;
         $display("FAIL reset_outputs: got wb_we=%b ready=%b, expected 0 000", bus.wb_we, bus.req_ready);
      end
      checks++;
      if (bus.wb_rd !== 5'd0 || bus.wb_f !== 1'b0 || bus.wb_data !== 32'd0 || bus.pending_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reset_regs: got rd=%0d f=%b data=%h cnt=%0d, expected all 0",
                  bus.wb_rd, bus.wb_f, bus.wb_data, bus.pending_cnt);
      end
      tick();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b0 || bus.stall !== 1'b0 || bus.pending_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reset_idle: got wb_we=%b stall=%b cnt=%0d, expected 0 0 0",
                  bus.wb_we, bus.stall, bus.pending_cnt);
      end
      $display("reset/idle checked");
   endtask

   task automatic test_contention();
      logic [31:0] dm [3];
      logic [2:0]  exp_rdy;
      wb_exp_t     e;
      do_reset();
      tick();
      for (int i = 0; i < 3; i++) begin
         dm[i] = 32'hC0DE_0000 + 32'(i);
         set_req(i, 1'b1, 5'(5 + i), 1'b0, dm[i]);
      end
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin
            tick();
            // previous winner presents a fresh result
            dm[order[c-1]] = dm[order[c-1]] + 32'h100;
            set_req(order[c-1], 1'b1, 5'(5 + order[c-1]), 1'b0, dm[order[c-1]]);
         end
         @(negedge clk);
         exp_rdy = 3'b001 << order[c];
         checks++;
         if (bus.req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant_order: cycle %0d got ready=%b, expected %b", c, bus.req_ready, exp_rdy);
         end else begin
            $display("grant cycle %0d ready=%b", c, bus.req_ready);
         end
         if (c > 0) begin
            checks++;
            if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'(5 + order[c-1])) begin
               errors++;
               $display("FAIL wb_latency: cycle %0d got we=%b rd=%0d, expected 1 %0d",
                        c, bus.wb_we, bus.wb_rd, 5 + order[c-1]);
            end
         end
         e.rd   = 5'(5 + order[c]);
         e.f    = 1'b0;
         e.data = dm[order[c]];
         exp_q.push_back(e);
      end
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd5 || bus.req_ready !== 3'b000) begin
         errors++;
         $display("FAIL wb_last: got we=%b rd=%0d ready=%b, expected 1 5 000",
                  bus.wb_we, bus.wb_rd, bus.req_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL wb_drain: got we=%b queued=%0d, expected 0 0", bus.wb_we, exp_q.size());
      end
   endtask

   task automatic test_raw();
      wb_exp_t e;
      logic    exp_stall_grant;
`ifdef WB_SCOREBOARD_BYPASS_EN
      exp_stall_grant = 1'b0;
`else
      exp_stall_grant = 1'b1;
`endif
      do_reset();
      tick();
      set_iss(1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL raw_first_issue: got stall=%b, expected 0", bus.stall);
      end
      tick();
      set_iss(1'b1, 1'b1, 5'd10, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1 || bus.pending_cnt !== 6'd1) begin
         errors++;
         $display("FAIL raw_stall: got stall=%b cnt=%0d, expected 1 1", bus.stall, bus.pending_cnt);
      end
      tick();
      set_req(2, 1'b1, 5'd8, 1'b0, 32'h8888_0008);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 3'b100 || bus.stall !== exp_stall_grant) begin
         errors++;
         $display("FAIL raw_grant_cycle: got ready=%b stall=%b, expected 100 %b",
                  bus.req_ready, bus.stall, exp_stall_grant);
      end
      e.rd = 5'd8; e.f = 1'b0; e.data = 32'h8888_0008;
      exp_q.push_back(e);
      tick();
      bus.req_valid = '0;
      if (!exp_stall_grant) begin
         bus.iss_valid = 1'b0;   // already accepted in the grant cycle
      end
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0 || bus.wb_we !== 1'b1) begin
         errors++;
         $display("FAIL raw_release: got stall=%b wb_we=%b, expected 0 1", bus.stall, bus.wb_we);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.pending_cnt !== 6'd1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL raw_pending: got cnt=%0d queued=%0d, expected 1 0", bus.pending_cnt, exp_q.size());
      end
      $display("raw scenario done");
   endtask

   task automatic test_bank_separation();
      wb_exp_t e;
      do_reset();
      tick();
      set_iss(1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL bank_issue_f3: got stall=%b, expected 0", bus.stall);
      end
      tick();
      set_iss(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0 || bus.pending_cnt !== 6'd1) begin
         errors++;
         $display("FAIL bank_read_x3: got stall=%b cnt=%0d, expected 0 1", bus.stall, bus.pending_cnt);
      end
      tick();
      set_iss(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL bank_read_f3: got stall=%b, expected 1", bus.stall);
      end
      tick();
      idle_inputs();
      set_req(1, 1'b1, 5'd3, 1'b1, 32'h0F0F_0003);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 3'b010) begin
         errors++;
         $display("FAIL bank_grant: got ready=%b, expected 010", bus.req_ready);
      end
      e.rd = 5'd3; e.f = 1'b1; e.data = 32'h0F0F_0003;
      exp_q.push_back(e);
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b1 || bus.wb_f !== 1'b1 || bus.pending_cnt !== 6'd0) begin
         errors++;
         $display("FAIL bank_clear: got we=%b f=%b cnt=%0d, expected 1 1 0",
                  bus.wb_we, bus.wb_f, bus.pending_cnt);
      end
      $display("bank separation done");
   endtask

   task automatic test_waw_x0();
      wb_exp_t e;
      do_reset();
      tick();
      set_iss(1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL x0_issue: got stall=%b, expected 0", bus.stall);
      end
      tick();
      set_iss(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0 || bus.pending_cnt !== 6'd0) begin
         errors++;
         $display("FAIL x0_read: got stall=%b cnt=%0d, expected 0 0", bus.stall, bus.pending_cnt);
      end
      tick();
      set_iss(1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL waw_first: got stall=%b, expected 0", bus.stall);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1 || bus.pending_cnt !== 6'd1) begin
         errors++;
         $display("FAIL waw_second: got stall=%b cnt=%0d, expected 1 1", bus.stall, bus.pending_cnt);
      end
      tick();
      idle_inputs();
      set_req(0, 1'b1, 5'd0, 1'b0, 32'hDEAD_0000);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 3'b001 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL x0_grant: got ready=%b stall=%b, expected 001 0", bus.req_ready, bus.stall);
      end
      e.rd = 5'd0; e.f = 1'b0; e.data = 32'hDEAD_0000;
      exp_q.push_back(e);
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd0 || bus.pending_cnt !== 6'd1) begin
         errors++;
         $display("FAIL x0_write: got we=%b rd=%0d cnt=%0d, expected 1 0 1",
                  bus.wb_we, bus.wb_rd, bus.pending_cnt);
      end
      $display("waw/x0 done");
   endtask

   task automatic test_reset_midop();
      do_reset();
      tick();
      set_iss(1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      set_iss(1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         set_req(i, 1'b1, 5'(20 + i), 1'b0, 32'h5A5A_0000 + 32'(i));
      end
      @(negedge clk);
      checks++;
      if (bus.pending_cnt !== 6'd1 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL midop_setup: got cnt=%0d stall=%b, expected 1 0", bus.pending_cnt, bus.stall);
      end
      // the grant made this cycle must be dropped by the reset
      tick();
      rst = 1'b1;
      bus.iss_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b0 || bus.req_ready !== 3'b000 || bus.pending_cnt !== 6'd2) begin
         errors++;
         $display("FAIL midop_rst_cycle: got we=%b ready=%b cnt=%0d, expected 0 000 2",
                  bus.wb_we, bus.req_ready, bus.pending_cnt);
      end
      tick();
      rst = 1'b0;
      idle_inputs();
      set_iss(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b1, 5'd12, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b0 || bus.pending_cnt !== 6'd0 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL midop_after: got we=%b cnt=%0d stall=%b, expected 0 0 0",
                  bus.wb_we, bus.pending_cnt, bus.stall);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bus.wb_we !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midop_quiet: got we=%b queued=%0d, expected 0 0", bus.wb_we, exp_q.size());
      end
      $display("reset mid-operation done");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_contention();
      test_raw();
      test_bank_separation();
      test_waw_x0();
      test_reset_midop();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
